// File: rtl/flit_tx_if.sv
// Requester-side and network-side signals of the flit transmit arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/network view.
interface flit_tx_if #(
   parameter int NUM_REQ         = 4,
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int NUM_VCS         = 2,
   parameter int DEST_BITS       = 2
);
   localparam int VC_BITS = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
   localparam int FW      = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*(FW-1)-1:0] req_flit;
   logic [NUM_REQ-1:0]        req_ready;
   logic [FW-1:0]             putFlit;
   logic                      EN_putFlit;
   logic [VC_BITS:0]          getCredits;
   logic                      EN_getCredits;

   modport master (
      output req_valid, req_flit, getCredits,
      input  req_ready, putFlit, EN_putFlit, EN_getCredits
   );
   modport slave (
      input  req_valid, req_flit, getCredits,
      output req_ready, putFlit, EN_putFlit, EN_getCredits
   );
endinterface

// File: rtl/flit_tx_arbiter.sv
// Round-robin, packet-locked arbiter that sends requester flits onto a credit-controlled network port.
// Defining FLIT_TX_CREDIT_CHK_EN adds the sticky credit_err output.
module flit_tx_credit_cnt #(
   parameter int BUF_DEPTH = 16,
   parameter int CNT_BITS  = 5
) (
   input  logic                CLK,
   input  logic                nreset,
   input  logic                dec,
   input  logic                inc,
   output logic [CNT_BITS-1:0] cnt
`ifdef FLIT_TX_CREDIT_CHK_EN
   ,
   output logic                err
`endif
);
   localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(BUF_DEPTH);

   // A simultaneous take and return cancel out. A return while the counter is full is dropped.
   always_ff @(posedge CLK or negedge nreset)
      if (!nreset)                         cnt <= FULL;
      else if (dec && !inc)                cnt <= cnt - 1'b1;
      else if (inc && !dec && cnt != FULL) cnt <= cnt + 1'b1;

`ifdef FLIT_TX_CREDIT_CHK_EN
   always_ff @(posedge CLK or negedge nreset)
      if (!nreset) err <= 1'b0;
      else if ((inc && !dec && cnt == FULL) || (dec && cnt == '0)) err <= 1'b1;
`endif
endmodule

module flit_tx_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int NUM_VCS         = 2,
   parameter int DEST_BITS       = 2,
   parameter int BUF_DEPTH       = 16
) (
   input  logic     CLK,
   input  logic     nreset,
   flit_tx_if.slave bus
`ifdef FLIT_TX_CREDIT_CHK_EN
   ,
   output logic     credit_err
`endif
);
   localparam int VC_BITS  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
   localparam int CNT_BITS = $clog2(BUF_DEPTH) + 1;
   localparam int FW       = 2 + DEST_BITS + VC_BITS + FLIT_DATA_WIDTH;
   localparam int RW       = FW - 1;
   localparam int OW_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]                         state;
   logic [OW_BITS-1:0]                 owner, last_owner, win_idx, idx;
   logic [NUM_REQ-1:0][RW-1:0]         flit_i;
   logic [NUM_REQ-1:0]                 eligible, grant;
   logic [NUM_VCS-1:0][CNT_BITS-1:0]   credit;
   logic [NUM_VCS-1:0]                 cred_dec, cred_inc;
   logic                               accept;
   logic [RW-1:0]                      acc_flit;
   logic [VC_BITS-1:0]                 acc_vc;
   logic [FW-1:0]                      put_q;
   logic                               en_put_q, en_get_q;

   assign flit_i = bus.req_flit;

   // A requester is eligible when it is valid and its flit's VC has at least one credit.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         for (int v = 0; v < NUM_VCS; v++)
            if (flit_i[i][FLIT_DATA_WIDTH +: VC_BITS] == VC_BITS'(v) && credit[v] != '0)
               eligible[i] = bus.req_valid[i];
   end

   always_comb begin
      accept  = 1'b0;
      win_idx = '0;
      idx     = '0;
      if (nreset) begin
         if (state == IDLE) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
               idx = OW_BITS'((int'(last_owner) + k) % NUM_REQ);
               if (!accept && eligible[idx]) begin
                  accept  = 1'b1;
                  win_idx = idx;
               end
            end
         end else if (eligible[owner]) begin
            accept  = 1'b1;
            win_idx = owner;
         end
      end
   end

   always_comb begin
      grant = '0;
      if (accept) grant[win_idx] = 1'b1;
   end

   assign acc_flit          = flit_i[win_idx];
   assign acc_vc            = acc_flit[FLIT_DATA_WIDTH +: VC_BITS];
   assign bus.req_ready     = grant;
   assign bus.putFlit       = put_q;
   assign bus.EN_putFlit    = en_put_q;
   assign bus.EN_getCredits = en_get_q;

   always_ff @(posedge CLK or negedge nreset)
      if (!nreset) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OW_BITS'(NUM_REQ - 1);
         put_q      <= '0;
         en_put_q   <= 1'b0;
         en_get_q   <= 1'b0;
      end else begin
         en_get_q <= 1'b1;
         en_put_q <= accept;
         put_q    <= accept ? {1'b1, acc_flit} : '0;
         if (accept) begin
            if (acc_flit[RW-1]) begin
               state      <= IDLE;
               last_owner <= win_idx;
            end else begin
               state <= LOCKED;
               owner <= win_idx;
            end
         end
      end

`ifdef FLIT_TX_CREDIT_CHK_EN
   logic [NUM_VCS-1:0] cnt_err;
   assign credit_err = |cnt_err;
`endif

   for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
      assign cred_dec[v] = accept && acc_vc == VC_BITS'(v);
      assign cred_inc[v] = bus.getCredits[VC_BITS] && bus.getCredits[VC_BITS-1:0] == VC_BITS'(v);
      flit_tx_credit_cnt #(.BUF_DEPTH(BUF_DEPTH), .CNT_BITS(CNT_BITS)) u_cnt (
         .CLK    (CLK),
         .nreset (nreset),
         .dec    (cred_dec[v]),
         .inc    (cred_inc[v]),
         .cnt    (credit[v])
`ifdef FLIT_TX_CREDIT_CHK_EN
         ,
         .err    (cnt_err[v])
`endif
      );
   end
endmodule

// File: tb/tb_flit_tx_arbiter.sv
// Directed bench for flit_tx_arbiter; expected values are hand-computed from the requirements.
module tb_flit_tx_arbiter;
   localparam int NR = 4, DW = 32, NV = 2, DB = 2, VB = 1, BD = 16;
   localparam int RW = 1 + DB + VB + DW;

   logic CLK = 1'b0;
   logic nreset = 1'b0;
   int   n_vec = 0, n_err = 0, n_acc;
`ifdef FLIT_TX_CREDIT_CHK_EN
   logic credit_err;
`endif

   flit_tx_if #(.NUM_REQ(NR), .FLIT_DATA_WIDTH(DW), .NUM_VCS(NV), .DEST_BITS(DB)) bus ();

   flit_tx_arbiter #(.NUM_REQ(NR), .FLIT_DATA_WIDTH(DW), .NUM_VCS(NV), .DEST_BITS(DB),
                     .BUF_DEPTH(BD)) dut (
      .CLK    (CLK),
      .nreset (nreset),
      .bus    (bus)
`ifdef FLIT_TX_CREDIT_CHK_EN
      ,
      .credit_err (credit_err)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] mk(input logic tail, input logic [DB-1:0] dest,
                                        input logic [VB-1:0] vc, input logic [DW-1:0] d);
      return {tail, dest, vc, d};
   endfunction

   task automatic setf(input int i, input logic [RW-1:0] f);
      bus.req_flit[i*RW +: RW] = f;
   endtask

   task automatic cyc;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      bus.req_valid  = '0;
      bus.req_flit   = '0;
      bus.getCredits = '0;
      // Requests presented during reset must not be granted
      bus.req_valid = 4'b0101;
      setf(0, mk(1'b1, 2'd1, 1'b0, 32'hA0));
      setf(2, mk(1'b1, 2'd3, 1'b0, 32'hA2));
      repeat (2) cyc;
      chk("rst_ready",  bus.req_ready, 4'b0000);
      chk("rst_en_put", bus.EN_putFlit, 1'b0);
      chk("rst_put",    bus.putFlit, '0);
      chk("rst_en_get", bus.EN_getCredits, 1'b0);
      chk("rst_cred0",  dut.credit[0], BD);
      chk("rst_cred1",  dut.credit[1], BD);
`ifdef FLIT_TX_CREDIT_CHK_EN
      chk("rst_err", credit_err, 1'b0);
`endif
      nreset = 1'b1;
      #1;

      // Two single-flit requesters on vc0: req0 first, then req2
      chk("a_ready0", bus.req_ready, 4'b0001);
      cyc;
      chk("a_put0",    bus.putFlit, {1'b1, mk(1'b1, 2'd1, 1'b0, 32'hA0)});
      chk("a_en_put0", bus.EN_putFlit, 1'b1);
      chk("a_en_get",  bus.EN_getCredits, 1'b1);
      bus.req_valid = 4'b0100;
      #1;
      chk("a_ready2", bus.req_ready, 4'b0100);
      cyc;
      chk("a_put2", bus.putFlit, {1'b1, mk(1'b1, 2'd3, 1'b0, 32'hA2)});
      bus.req_valid = 4'b0000;
      cyc;
      chk("a_idle_en", bus.EN_putFlit, 1'b0);
      chk("a_idle_put", bus.putFlit, '0);
      chk("a_cred0", dut.credit[0], 14);

      // Three-flit packet from req1 holds off req3 until the tail
      setf(1, mk(1'b0, 2'd2, 1'b0, 32'hB0));
      bus.req_valid = 4'b0010;
      #1;
      chk("b_head_ready", bus.req_ready, 4'b0010);
      cyc;
      chk("b_put_head", bus.putFlit, {1'b1, mk(1'b0, 2'd2, 1'b0, 32'hB0)});
      setf(1, mk(1'b0, 2'd2, 1'b0, 32'hB1));
      setf(3, mk(1'b1, 2'd0, 1'b0, 32'hD3));
      bus.req_valid = 4'b1010;
      #1;
      chk("b_body_ready", bus.req_ready, 4'b0010);
      cyc;
      chk("b_put_body", bus.putFlit, {1'b1, mk(1'b0, 2'd2, 1'b0, 32'hB1)});
      setf(1, mk(1'b1, 2'd2, 1'b0, 32'hB2));
      #1;
      chk("b_tail_ready", bus.req_ready, 4'b0010);
      cyc;
      chk("b_put_tail", bus.putFlit, {1'b1, mk(1'b1, 2'd2, 1'b0, 32'hB2)});
      bus.req_valid = 4'b1000;
      #1;
      chk("b_req3_ready", bus.req_ready, 4'b1000);
      cyc;
      chk("b_put_req3", bus.putFlit, {1'b1, mk(1'b1, 2'd0, 1'b0, 32'hD3)});
      bus.req_valid = 4'b0000;
      cyc;
      chk("b_cred0", dut.credit[0], 10);

      // 17 flits on vc1 with no returns: exactly 16 go out
      setf(0, mk(1'b1, 2'd1, 1'b1, 32'hC0));
      bus.req_valid = 4'b0001;
      n_acc = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (bus.req_ready[0]) n_acc++;
         cyc;
      end
      chk("c_accepts", n_acc, 16);
      chk("c_cred1_zero", dut.credit[1], 0);
      // vc1 starved, vc0 still flows
      setf(2, mk(1'b1, 2'd1, 1'b0, 32'hC2));
      bus.req_valid = 4'b0101;
      #1;
      chk("c_vc0_flows", bus.req_ready, 4'b0100);
      cyc;
      bus.req_valid  = 4'b0001;
      bus.getCredits = 2'b11;
      #1;
      chk("c_stall_ret", bus.req_ready, 4'b0000);
      cyc;
      bus.getCredits = 2'b00;
      #1;
      chk("c_cred1_one", dut.credit[1], 1);
      chk("c_17th_ready", bus.req_ready, 4'b0001);
      cyc;
      chk("c_put_17th", bus.putFlit, {1'b1, mk(1'b1, 2'd1, 1'b1, 32'hC0)});
      bus.req_valid = 4'b0000;
      chk("c_cred1_end", dut.credit[1], 0);

      // Drain vc0 to 5, then take and return in the same cycle
      setf(2, mk(1'b1, 2'd0, 1'b0, 32'hD0));
      bus.req_valid = 4'b0100;
      repeat (4) cyc;
      bus.req_valid = 4'b0000;
      chk("d_cred0_5", dut.credit[0], 5);
      bus.req_valid  = 4'b0100;
      bus.getCredits = 2'b10;
      #1;
      chk("d_same_ready", bus.req_ready, 4'b0100);
      cyc;
      bus.req_valid  = 4'b0000;
      bus.getCredits = 2'b00;
      chk("d_cred0_hold", dut.credit[0], 5);
      chk("d_put", bus.putFlit, {1'b1, mk(1'b1, 2'd0, 1'b0, 32'hD0)});
      bus.getCredits = 2'b10;
      cyc;
      bus.getCredits = 2'b00;
      chk("d_cred0_inc", dut.credit[0], 6);

      // Reset while locked after the head flit
      setf(1, mk(1'b0, 2'd3, 1'b0, 32'hE0));
      bus.req_valid = 4'b0010;
      #1;
      chk("e_head_ready", bus.req_ready, 4'b0010);
      cyc;
      chk("e_head_put", bus.EN_putFlit, 1'b1);
      setf(1, mk(1'b0, 2'd3, 1'b0, 32'hE1));
      #1;
      chk("e_lock_ready", bus.req_ready, 4'b0010);
      nreset = 1'b0;
      #1;
      chk("e_rst_en_put", bus.EN_putFlit, 1'b0);
      chk("e_rst_put",    bus.putFlit, '0);
      chk("e_rst_ready",  bus.req_ready, 4'b0000);
      chk("e_rst_cred0",  dut.credit[0], BD);
      chk("e_rst_cred1",  dut.credit[1], BD);
      chk("e_rst_state",  dut.state, 1'b0);
      bus.req_valid = 4'b0000;
      cyc;
      nreset = 1'b1;
      cyc;
      chk("e_no_flit1", bus.EN_putFlit, 1'b0);
      cyc;
      chk("e_no_flit2", bus.EN_putFlit, 1'b0);
      chk("e_state_idle", dut.state, 1'b0);

      // Return on an already-full counter
      bus.getCredits = 2'b10;
      cyc;
      bus.getCredits = 2'b00;
      chk("f_full_hold", dut.credit[0], BD);
`ifdef FLIT_TX_CREDIT_CHK_EN
      chk("f_err_set", credit_err, 1'b1);
      cyc;
      chk("f_err_sticky", credit_err, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
